issue_scheduler: RTL and testbench
==================================

// Module: issue_scheduler
// PURPOSE
//  Decode-stage issue controller for the vi_core pipeline. It owns the single int_registers write port.
//  That port is shared by the ALU path (latency 1), the cache path (latency 2) and the mult1..mult5 path (latency 5).
//  A latency-indexed reservation shift register tracks every in-flight write.
//  The block stalls decode on RAW, WAW and write-port conflicts and announces the owner of each writeback cycle.
// PARAMETERS
//  ADDR_W     5   register address width
//  NUM_REGS   32  architectural integer registers; r0 is never reserved or hazarded
//  ALU_LAT    1   cycles from issue to write slot, ALU class
//  MEM_LAT    2   cycles from issue to write slot, cache class
//  MUL_LAT    5   cycles from issue to write slot, mult class
//  RES_DEPTH  8   reservation slots; must be > max latency
// PORTS
//  clk_i           in   1         core clock
//  rsn_i           in   1         async active-low reset
//  dec_valid_i     in   1         decode holds a valid instruction
//  dec_class_i     in   2         0=ALU 1=MUL 2=MEM 3=no-write
//  dec_rs1_i       in   ADDR_W    source A address
//  dec_rs1_used_i  in   1         source A is read
//  dec_rs2_i       in   ADDR_W    source B address
//  dec_rs2_used_i  in   1         source B is read
//  dec_rd_i        in   ADDR_W    destination address
//  dec_wr_en_i     in   1         instruction writes rd
//  flush_i         in   1         kill decode instruction this cycle
//  issue_o         out  1         instruction leaves decode at this edge
//  stall_o         out  1         hold fetch/decode latches
//  wb_valid_o      out  1         write port owned this cycle
//  wb_rd_o         out  ADDR_W    register written this cycle
//  wb_class_o      out  2         unit driving write data this cycle
//  busy_regs_o     out  NUM_REGS  bit r set = pending write to r, not yet bypassable
//  stall_cnt_o     out  16        saturating count of stall cycles
// BEHAVIOUR
//  State: slot[0..RES_DEPTH-1] = {v, rd, class}.
//  - slot[k] writes k cycles from now; slot[0] is on the write bus and bypass network this cycle.
//  - Every edge: slot[k] <= slot[k+1]; slot[RES_DEPTH-1] <= empty.
//  - On issue with latency L (L from class), slot[L-1] <= {1, rd, class}, overriding the shift value.
//  - An entry is written only if dec_wr_en_i=1, class!=3 and rd!=0.
//  Hazards, combinational on current state (src = rs1 if used, rs2 if used; src 0 ignored):
//  - RAW: some valid slot[k] with k>=1 has rd==src. slot[0] matches are bypassed, no stall.
//  - PORT: instruction will write and slot[L] is valid (slot index >= RES_DEPTH is empty).
//  - WAW: instruction will write and some valid slot[k] with k>=L has rd==dec_rd_i.
//  - hazard = RAW | PORT | WAW.
//  Issue/stall:
//  - issue_o = dec_valid_i & ~flush_i & ~hazard.
//  - stall_o = dec_valid_i & ~flush_i & hazard.
//  - flush_i wins: no issue, no stall, no reservation; in-flight slots are untouched.
//  Outputs:
//  - wb_valid_o, wb_rd_o and wb_class_o = slot[0] fields; these are registered state with no input path.
//  - busy_regs_o[r] = OR over k>=1 of (slot[k].v & slot[k].rd==r). Bit 0 is always 0.
//  - stall_cnt_o += 1 on each stall_o cycle and saturates at 16'hFFFF.
//  Reset (rsn_i low, asynchronous):
//  - All slots invalid and stall_cnt_o=0.
//  - wb_valid_o=0, wb_rd_o=0, wb_class_o=0, busy_regs_o=0.
//  - issue_o then follows dec_valid_i & ~flush_i.
//  - Reset mid-operation discards in-flight reservations and does not wait for them to drain.
//  Simultaneous events:
//  - Shift and insert share one edge; insert uses post-shift indexing (slot[L-1]).
//  - An instruction may read a reg whose write is in slot[0] and also issue this cycle.
// TESTING (t0 = first cycle after reset release)
//  1 MUL rd=3 at t0; ALU rs1=3 held from t1 -> stall_o=1 t1..t4, issue_o=1 t5; wb_valid_o=1, wb_rd_o=3, wb_class_o=1 at t5.
//  2 MUL rd=4 at t0; ALU rd=5 (no deps) at t4 -> PORT stall at t4, issue at t5; wb_rd_o=4 at t5, 5 at t6.
//  3 MUL rd=6 at t0; ALU rd=6 at t1 -> stall t1..t4, issue t5; wb order rd 6 (class1) then rd 6 (class0).
//  4 MUL rd=0, then ALU rs1=0, rs2=0 -> no stall; wb_valid_o never 1; busy_regs_o=0.
//  5 MUL rd=7 at t0, drop rsn_i at t2 -> wb_valid_o=0, busy_regs_o=0, stall_cnt_o=0 immediately; no write of r7 after release.
//  6 Hazarded instruction with flush_i=1 -> issue_o=0, stall_o=0, stall_cnt_o unchanged; stall counter preset near 16'hFFFF by long stall saturates.

Source files
------------

// File: rtl/issue_scheduler_if.sv
// Decode/writeback bundle between the decode stage and the issue scheduler.
// The decode side drives the instruction fields; the scheduler answers with issue/stall and writeback ownership.
interface issue_scheduler_if #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
);
  logic              dec_valid_i;
  logic [1:0]        dec_class_i;
  logic [ADDR_W-1:0] dec_rs1_i;
  logic              dec_rs1_used_i;
  logic [ADDR_W-1:0] dec_rs2_i;
  logic              dec_rs2_used_i;
  logic [ADDR_W-1:0] dec_rd_i;
  logic              dec_wr_en_i;
  logic              flush_i;
  logic              issue_o;
  logic              stall_o;
  logic              wb_valid_o;
  logic [ADDR_W-1:0] wb_rd_o;
  logic [1:0]        wb_class_o;
  logic [NUM_REGS-1:0] busy_regs_o;
  logic [15:0]       stall_cnt_o;

  modport master (
    output dec_valid_i, dec_class_i,
    output dec_rs1_i, dec_rs1_used_i,
    output dec_rs2_i, dec_rs2_used_i,
    output dec_rd_i, dec_wr_en_i, flush_i,
    input  issue_o, stall_o,
    input  wb_valid_o, wb_rd_o, wb_class_o,
    input  busy_regs_o, stall_cnt_o
  );

  modport slave (
    input  dec_valid_i, dec_class_i,
    input  dec_rs1_i, dec_rs1_used_i,
    input  dec_rs2_i, dec_rs2_used_i,
    input  dec_rd_i, dec_wr_en_i, flush_i,
    output issue_o, stall_o,
    output wb_valid_o, wb_rd_o, wb_class_o,
    output busy_regs_o, stall_cnt_o
  );
endinterface

// File: rtl/issue_scheduler.sv
// Decode-stage issue controller owning the single integer write port.
// A latency-indexed reservation shift register tracks every in-flight write.
module issue_scheduler #(
  parameter int ADDR_W    = 5,
  parameter int NUM_REGS  = 32,
  parameter int ALU_LAT   = 1,
  parameter int MEM_LAT   = 2,
  parameter int MUL_LAT   = 5,
  parameter int RES_DEPTH = 8
) (
  input logic clk_i,
  input logic rsn_i,
  issue_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(RES_DEPTH);

  logic [RES_DEPTH-1:0] sv;
  logic [ADDR_W-1:0]    srd  [RES_DEPTH];
  logic [1:0]           scls [RES_DEPTH];
  logic [15:0]          cnt;

  int               lat;
  logic [IDX_W-1:0] ins;
  logic             wr;
  logic             raw;
  logic             port;
  logic             waw;
  logic             hazard;
  logic             go;
  logic             hold;

  always_comb begin
    lat = ALU_LAT;
    unique case (1'b1)
      bus.dec_class_i == 2'd1: lat = MUL_LAT;
      bus.dec_class_i == 2'd2: lat = MEM_LAT;
      default:                 lat = ALU_LAT;
    endcase
  end

  assign ins = IDX_W'(lat - 1);
  assign wr  = bus.dec_wr_en_i
             & (bus.dec_class_i != 2'd3)
             & (bus.dec_rd_i != '0);

  // slot[0] is on the bypass network, so only k>=1 can cause RAW
  always_comb begin
    raw  = 1'b0;
    port = 1'b0;
    waw  = 1'b0;
    for (int k = 1; k < RES_DEPTH; k++) begin
      if (sv[k]) begin
        if (bus.dec_rs1_used_i
            && bus.dec_rs1_i != '0
            && srd[k] == bus.dec_rs1_i)
          raw = 1'b1;
        if (bus.dec_rs2_used_i
            && bus.dec_rs2_i != '0
            && srd[k] == bus.dec_rs2_i)
          raw = 1'b1;
        if (wr && k >= lat
            && srd[k] == bus.dec_rd_i)
          waw = 1'b1;
        if (wr && k == lat)
          port = 1'b1;
      end
    end
  end

  assign hazard = raw | port | waw;
  assign go     = bus.dec_valid_i & ~bus.flush_i & ~hazard;
  assign hold   = bus.dec_valid_i & ~bus.flush_i & hazard;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      sv  <= '0;
      cnt <= '0;
      for (int k = 0; k < RES_DEPTH; k++) begin
        srd[k]  <= '0;
        scls[k] <= '0;
      end
    end else begin
      for (int k = 0; k < RES_DEPTH - 1; k++) begin
        sv[k]   <= sv[k+1];
        srd[k]  <= srd[k+1];
        scls[k] <= scls[k+1];
      end
      sv[RES_DEPTH-1]   <= 1'b0;
      srd[RES_DEPTH-1]  <= '0;
      scls[RES_DEPTH-1] <= '0;
      // insert uses post-shift indexing, overriding the shifted value
      if (go && wr) begin
        sv[ins]   <= 1'b1;
        srd[ins]  <= bus.dec_rd_i;
        scls[ins] <= bus.dec_class_i;
      end
      if (hold && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    bus.busy_regs_o = '0;
    for (int k = 1; k < RES_DEPTH; k++)
      if (sv[k])
        bus.busy_regs_o[srd[k]] = 1'b1;
    bus.busy_regs_o[0] = 1'b0;
  end

  assign bus.issue_o     = go;
  assign bus.stall_o     = hold;
  assign bus.wb_valid_o  = sv[0];
  assign bus.wb_rd_o     = srd[0];
  assign bus.wb_class_o  = scls[0];
  assign bus.stall_cnt_o = cnt;
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: hazard vector table
// followed by multi-cycle writeback, reset and saturation sequences.
module tb_issue_scheduler;
  logic clk;
  logic rsn;
  int   total;
  int   bad;

  issue_scheduler_if #(.ADDR_W(5), .NUM_REGS(32)) bus ();

  issue_scheduler dut (
    .clk_i (clk),
    .rsn_i (rsn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] p_cls;
    logic [4:0] p_rd;
    int         gap;
    logic [1:0] cls;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       fl;
    logic       e_iss;
    logic       e_stl;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [1:0] c,
                     input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2,
                     input logic [4:0] rd, input logic we,
                     input logic fl);
    bus.dec_valid_i    = v;
    bus.dec_class_i    = c;
    bus.dec_rs1_i      = r1;
    bus.dec_rs1_used_i = u1;
    bus.dec_rs2_i      = r2;
    bus.dec_rs2_used_i = u2;
    bus.dec_rd_i       = rd;
    bus.dec_wr_en_i    = we;
    bus.flush_i        = fl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rsn = 1'b0;
    repeat (2) @(negedge clk);
    rsn = 1'b1;
  endtask

  function automatic int lat_of(input logic [1:0] c);
    case (c)
      2'd1:    return 5;
      2'd2:    return 2;
      default: return 1;
    endcase
  endfunction

  initial begin
    int idx;
    logic pw;
    logic [31:0] eb;
    logic seen;
    total = 0;
    bad   = 0;
    rsn   = 1'b0;
    idle();

    //          pc pr gp cl rs1 u1 rs2 u2 rd we fl iss stl
    vt[0]  = '{1, 3, 0, 0, 3, 1, 0, 0, 8, 1, 0, 0, 1};
    vt[1]  = '{1, 3, 3, 0, 3, 1, 0, 0, 8, 1, 0, 0, 1};
    vt[2]  = '{1, 3, 4, 0, 3, 1, 0, 0, 8, 1, 0, 1, 0};
    vt[3]  = '{1, 3, 0, 0, 3, 0, 0, 0, 8, 1, 0, 1, 0};
    vt[4]  = '{1, 4, 3, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1};
    vt[5]  = '{1, 4, 3, 2, 0, 0, 0, 0, 5, 1, 0, 1, 0};
    vt[6]  = '{1, 4, 3, 0, 0, 0, 0, 0, 5, 0, 0, 1, 0};
    vt[7]  = '{1, 6, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 1};
    vt[8]  = '{1, 6, 0, 1, 0, 0, 0, 0, 6, 1, 0, 1, 0};
    vt[9]  = '{2, 9, 0, 1, 0, 0, 9, 1, 7, 1, 0, 0, 1};
    vt[10] = '{1, 3, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    vt[11] = '{1, 3, 0, 0, 3, 1, 0, 0, 8, 1, 1, 0, 0};
    vt[12] = '{0, 10, 0, 0, 10, 1, 0, 0, 8, 1, 0, 1, 0};
    vt[13] = '{2, 11, 0, 0, 0, 0, 0, 0, 12, 1, 0, 0, 1};
    vt[14] = '{3, 3, 0, 0, 3, 1, 0, 0, 8, 1, 0, 1, 0};

    do_reset();
    #1;
    chk("rst_wb_valid", 32'(bus.wb_valid_o), 0);
    chk("rst_wb_rd", 32'(bus.wb_rd_o), 0);
    chk("rst_wb_class", 32'(bus.wb_class_o), 0);
    chk("rst_busy", bus.busy_regs_o, 0);
    chk("rst_cnt", 32'(bus.stall_cnt_o), 0);

    for (int i = 0; i < 15; i++) begin
      do_reset();
      drv(1, vt[i].p_cls, 0, 0, 0, 0, vt[i].p_rd, 1, 0);
      @(negedge clk);
      for (int g = 0; g < vt[i].gap; g++) begin
        idle();
        @(negedge clk);
      end
      drv(1, vt[i].cls, vt[i].rs1, vt[i].u1,
          vt[i].rs2, vt[i].u2, vt[i].rd,
          vt[i].we, vt[i].fl);
      #1;
      idx = lat_of(vt[i].p_cls) - 1 - vt[i].gap;
      pw  = (vt[i].p_cls != 3) && (vt[i].p_rd != 0);
      eb  = (pw && idx >= 1) ? (32'd1 << vt[i].p_rd) : 32'd0;
      chk($sformatf("v%0d_issue", i), 32'(bus.issue_o), 32'(vt[i].e_iss));
      chk($sformatf("v%0d_stall", i), 32'(bus.stall_o), 32'(vt[i].e_stl));
      chk($sformatf("v%0d_busy", i), bus.busy_regs_o, eb);
      chk($sformatf("v%0d_wbv", i), 32'(bus.wb_valid_o), 32'(pw && idx == 0));
    end

    // RAW on a MUL result: four stalls, then bypass issue
    do_reset();
    drv(1, 1, 0, 0, 0, 0, 3, 1, 0);
    #1 chk("s1_t0_issue", 32'(bus.issue_o), 1);
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      drv(1, 0, 3, 1, 0, 0, 8, 0, 0);
      #1;
      chk($sformatf("s1_t%0d_stall", t), 32'(bus.stall_o), 32'(t < 5));
      chk($sformatf("s1_t%0d_issue", t), 32'(bus.issue_o), 32'(t == 5));
    end
    chk("s1_wbv", 32'(bus.wb_valid_o), 1);
    chk("s1_wbrd", 32'(bus.wb_rd_o), 3);
    chk("s1_wbcls", 32'(bus.wb_class_o), 1);
    chk("s1_cnt", 32'(bus.stall_cnt_o), 4);

    // write-port conflict
    do_reset();
    drv(1, 1, 0, 0, 0, 0, 4, 1, 0);
    repeat (3) begin
      @(negedge clk);
      idle();
    end
    @(negedge clk);
    drv(1, 0, 0, 0, 0, 0, 5, 1, 0);
    #1 chk("s2_t4_stall", 32'(bus.stall_o), 1);
    @(negedge clk);
    #1;
    chk("s2_t5_issue", 32'(bus.issue_o), 1);
    chk("s2_t5_wbrd", 32'(bus.wb_rd_o), 4);
    @(negedge clk);
    idle();
    #1;
    chk("s2_t6_wbv", 32'(bus.wb_valid_o), 1);
    chk("s2_t6_wbrd", 32'(bus.wb_rd_o), 5);

    // WAW ordering
    do_reset();
    drv(1, 1, 0, 0, 0, 0, 6, 1, 0);
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      drv(1, 0, 0, 0, 0, 0, 6, 1, 0);
      #1 chk($sformatf("s3_t%0d_issue", t), 32'(bus.issue_o), 32'(t == 5));
    end
    chk("s3_t5_wbcls", 32'(bus.wb_class_o), 1);
    chk("s3_t5_wbrd", 32'(bus.wb_rd_o), 6);
    @(negedge clk);
    idle();
    #1;
    chk("s3_t6_wbv", 32'(bus.wb_valid_o), 1);
    chk("s3_t6_wbcls", 32'(bus.wb_class_o), 0);
    chk("s3_t6_wbrd", 32'(bus.wb_rd_o), 6);

    // r0 never reserved
    do_reset();
    drv(1, 1, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    drv(1, 0, 0, 1, 0, 1, 0, 1, 0);
    #1;
    chk("s4_issue", 32'(bus.issue_o), 1);
    chk("s4_stall", 32'(bus.stall_o), 0);
    chk("s4_busy", bus.busy_regs_o, 0);
    seen = 1'b0;
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      idle();
      #1 seen = seen | bus.wb_valid_o;
    end
    chk("s4_no_wb", 32'(seen), 0);

    // async reset discards in-flight work
    do_reset();
    drv(1, 1, 0, 0, 0, 0, 7, 1, 0);
    @(negedge clk);
    drv(1, 0, 7, 1, 0, 0, 8, 0, 0);
    #1 chk("s5_busy_pre", bus.busy_regs_o, 32'd1 << 7);
    @(negedge clk);
    idle();
    #1 chk("s5_cnt_pre", 32'(bus.stall_cnt_o), 1);
    rsn = 1'b0;
    #1;
    chk("s5_wbv", 32'(bus.wb_valid_o), 0);
    chk("s5_busy", bus.busy_regs_o, 0);
    chk("s5_cnt", 32'(bus.stall_cnt_o), 0);
    @(negedge clk);
    rsn = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      #1 seen = seen | bus.wb_valid_o;
    end
    chk("s5_no_wb", 32'(seen), 0);

    // flush suppresses stall and counting
    do_reset();
    drv(1, 1, 0, 0, 0, 0, 3, 1, 0);
    @(negedge clk);
    drv(1, 0, 3, 1, 0, 0, 8, 1, 1);
    #1;
    chk("s6_fl_issue", 32'(bus.issue_o), 0);
    chk("s6_fl_stall", 32'(bus.stall_o), 0);
    @(negedge clk);
    #1 chk("s6_fl_cnt", 32'(bus.stall_cnt_o), 0);

    // self-dependent MUL: four stalls every five cycles
    do_reset();
    drv(1, 1, 3, 1, 0, 0, 3, 1, 0);
    repeat (500) @(negedge clk);
    #1 chk("s6_cnt_400", 32'(bus.stall_cnt_o), 400);
    repeat (81420) @(negedge clk);
    #1 chk("s6_cnt_sat", 32'(bus.stall_cnt_o), 32'hFFFF);
    repeat (10) @(negedge clk);
    #1 chk("s6_cnt_hold", 32'(bus.stall_cnt_o), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
